// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory bus of the load/store unit.
// Pure wiring: no storage, no latency.
// Backpressure is req_ready from the LSU; responses and memory controls cannot be stalled.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_fault;
    logic [63:0] rsp_rdata;
    logic [63:0] Mem_Addr;
    logic [63:0] Write_Data;
    logic        MemWrite;
    logic        MemRead;
    logic [63:0] Read_Data;

    // LSU side
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, Read_Data,
        output req_ready, rsp_valid, rsp_fault, rsp_rdata,
               Mem_Addr, Write_Data, MemWrite, MemRead
    );

    // pipeline + memory side
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, Read_Data,
        input  req_ready, rsp_valid, rsp_fault, rsp_rdata,
               Mem_Addr, Write_Data, MemWrite, MemRead
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store sequencer; sub-doubleword stores done as read-modify-write.
// Latency (accept edge to rsp_valid edge): load 1, sd 1, sb/sh/sw 2, fault 0.
// Backpressure: req_ready high only in IDLE; one request outstanding. Define LSU_ALIGN_CHECK_EN to fault misaligned accesses.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    load_store_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, ST_RD, ST_WR} state_t;

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [2:0]  f3_q, f3_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] merge_q, merge_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_fault_q, rsp_fault_d;
    logic [63:0] rsp_rdata_q, rsp_rdata_d;

    logic        accept;
    logic        illegal;
    logic        out_of_range;
    logic        fault;
    logic [64:0] last_byte;
    logic [63:0] load_ext;
    logic [63:0] merged;

    assign accept    = bus.req_valid && (state_q == IDLE);
    assign illegal   = bus.req_we ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
    // 65-bit sum so an address near 2^64 cannot wrap back into range
    assign last_byte    = {1'b0, bus.req_addr} + 65'd7;
    assign out_of_range = last_byte > 65'(MEM_BYTES - 1);

`ifdef LSU_ALIGN_CHECK_EN
    logic misaligned;
    // access size is 1 << funct3[1:0]; the low address bits below that size must be zero
    always_comb begin
        misaligned = 1'b0;
        case (bus.req_funct3[1:0])
            2'b01:   misaligned = bus.req_addr[0];
            2'b10:   misaligned = |bus.req_addr[1:0];
            2'b11:   misaligned = |bus.req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end
    assign fault = illegal || out_of_range || misaligned;
`else
    assign fault = illegal || out_of_range;
`endif

    // sign/zero extension of the low bytes of the memory word for the pending load
    always_comb begin
        load_ext = 64'd0;
        case (f3_q)
            3'b000:  load_ext = {{56{bus.Read_Data[7]}},  bus.Read_Data[7:0]};
            3'b001:  load_ext = {{48{bus.Read_Data[15]}}, bus.Read_Data[15:0]};
            3'b010:  load_ext = {{32{bus.Read_Data[31]}}, bus.Read_Data[31:0]};
            3'b011:  load_ext = bus.Read_Data;
            3'b100:  load_ext = {56'd0, bus.Read_Data[7:0]};
            3'b101:  load_ext = {48'd0, bus.Read_Data[15:0]};
            3'b110:  load_ext = {32'd0, bus.Read_Data[31:0]};
            default: load_ext = 64'd0;
        endcase
    end

    // splice the store bytes into the doubleword just read back
    always_comb begin
        merged = wdata_q;
        case (f3_q[1:0])
            2'b00:   merged = {bus.Read_Data[63:8],  wdata_q[7:0]};
            2'b01:   merged = {bus.Read_Data[63:16], wdata_q[15:0]};
            2'b10:   merged = {bus.Read_Data[63:32], wdata_q[31:0]};
            default: merged = wdata_q;
        endcase
    end

    // next-state and next-response computation
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        f3_d        = f3_q;
        wdata_d     = wdata_q;
        merge_d     = merge_q;
        rsp_valid_d = 1'b0;
        rsp_fault_d = 1'b0;
        rsp_rdata_d = 64'd0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = bus.req_addr;
                    f3_d    = bus.req_funct3;
                    wdata_d = bus.req_wdata;
                    merge_d = bus.req_wdata;
                    if (fault) begin
                        // suppressed: answer straight away, never touch memory
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = 1'b1;
                    end else if (!bus.req_we) begin
                        state_d = LOAD;
                    end else if (bus.req_funct3[1:0] == 2'b11) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            LOAD: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = load_ext;
                state_d     = IDLE;
            end
            ST_RD: begin
                merge_d = merged;
                state_d = ST_WR;
            end
            ST_WR: begin
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and request/response registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= 64'd0;
            f3_q        <= 3'd0;
            wdata_q     <= 64'd0;
            merge_q     <= 64'd0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= 64'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            f3_q        <= f3_d;
            wdata_q     <= wdata_d;
            merge_q     <= merge_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // memory controls follow the state directly so reset kills them without waiting for an edge
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.MemRead    = (state_q == LOAD) || (state_q == ST_RD);
    assign bus.MemWrite   = (state_q == ST_WR);
    assign bus.Mem_Addr   = addr_q;
    assign bus.Write_Data = merge_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_fault  = rsp_fault_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory, timeline reference model, per-cycle compare.
// Requests are issued only when the model says the unit is idle; garbage is driven while busy.
// Directed cases first, then randomized loads/stores/faults, then a full memory compare.
module tb_load_store_unit;
    localparam int MEM_BYTES = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus();
    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    logic [7:0] mem     [MEM_BYTES] = '{default: 8'h00};
    logic [7:0] ref_mem [MEM_BYTES] = '{default: 8'h00};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // expectations keyed by cycle index (number of rising edges seen)
    bit          exp_busy  [int];
    bit          exp_rd    [int];
    bit          exp_wr    [int];
    bit          exp_rsp   [int];
    logic        exp_fault [int];
    logic [63:0] exp_rdata [int];
    logic [63:0] exp_addr  [int];
    logic [63:0] exp_wd    [int];
    logic [63:0] exp_lit   [int];

    logic       bd_vld = 1'b0;
    int         bd_idx = 0;
    logic [7:0] bd_val = 8'h00;
    bit         do_final = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // data memory: combinational read, write at the edge while MemWrite
    always_comb begin
        bus.Read_Data = 64'd0;
        if (bus.Mem_Addr <= 64'(MEM_BYTES - 8))
            for (int i = 0; i < 8; i++) bus.Read_Data[8*i +: 8] = mem[int'(bus.Mem_Addr) + i];
    end

    always @(posedge clk) begin
        if (bd_vld) mem[bd_idx] <= bd_val;
        if (bus.MemWrite && bus.Mem_Addr <= 64'(MEM_BYTES - 8))
            for (int i = 0; i < 8; i++) mem[int'(bus.Mem_Addr) + i] <= bus.Write_Data[8*i +: 8];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // compare process: one sample per cycle, plus one right after reset is asserted
    always begin
        @(negedge clk or negedge reset_n);
        #1;
        if (!reset_n) begin
            chk("rst_req_ready",  64'(bus.req_ready), 64'd1);
            chk("rst_rsp_valid",  64'(bus.rsp_valid), 64'd0);
            chk("rst_rsp_fault",  64'(bus.rsp_fault), 64'd0);
            chk("rst_rsp_rdata",  bus.rsp_rdata, 64'd0);
            chk("rst_MemRead",    64'(bus.MemRead), 64'd0);
            chk("rst_MemWrite",   64'(bus.MemWrite), 64'd0);
            chk("rst_Mem_Addr",   bus.Mem_Addr, 64'd0);
            chk("rst_Write_Data", bus.Write_Data, 64'd0);
        end else begin
            chk("req_ready", 64'(bus.req_ready), 64'(!exp_busy.exists(cyc)));
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rsp.exists(cyc) != 0));
            chk("MemRead",   64'(bus.MemRead),   64'(exp_rd.exists(cyc) != 0));
            chk("MemWrite",  64'(bus.MemWrite),  64'(exp_wr.exists(cyc) != 0));
            if (exp_rsp.exists(cyc)) begin
                chk("rsp_fault", 64'(bus.rsp_fault), 64'(exp_fault[cyc]));
                chk("rsp_rdata", bus.rsp_rdata, exp_rdata[cyc]);
                if (exp_lit.exists(cyc)) begin
                    chk("rdata_literal", bus.rsp_rdata, exp_lit[cyc]);
                    chk("model_vs_literal", exp_rdata[cyc], exp_lit[cyc]);
                end
            end
            if (exp_rd.exists(cyc) || exp_wr.exists(cyc))
                chk("Mem_Addr", bus.Mem_Addr, exp_addr[cyc]);
            if (exp_wr.exists(cyc))
                chk("Write_Data", bus.Write_Data, exp_wd[cyc]);
        end
        if (do_final) begin
            for (int i = 0; i < MEM_BYTES; i++)
                chk($sformatf("mem[%0d]", i), 64'(mem[i]), 64'(ref_mem[i]));
            do_final = 1'b0;
        end
    end

    task automatic poke(input int idx, input logic [7:0] val);
        ref_mem[idx] = val;
        bd_idx = idx;
        bd_val = val;
        bd_vld = 1'b1;
        @(negedge clk);
        bd_vld = 1'b0;
    endtask

    task automatic drive_garbage();
        bus.req_valid  = 1'($urandom_range(0, 1));
        bus.req_we     = 1'($urandom_range(0, 1));
        bus.req_funct3 = 3'($urandom_range(0, 7));
        bus.req_addr   = 64'($urandom_range(0, 63));
        bus.req_wdata  = {$urandom, $urandom};
    endtask

    // Called at a falling edge while idle: predict the outcome, present the request,
    // and return at the falling edge where the response is visible (unit idle again).
    task automatic issue(input bit we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, input bit lit_en, input logic [63:0] lit_val,
                         input bit kill);
        int k, lat, size, a;
        bit flt;
        logic [63:0] val;
        logic [7:0] saved [MEM_BYTES];
        saved = ref_mem;
        k    = cyc + 1;
        size = 1 << f3[1:0];
        flt  = we ? f3[2] : (f3 == 3'b111);
        if (addr > 64'(MEM_BYTES - 8)) flt = 1'b1;
`ifdef LSU_ALIGN_CHECK_EN
        if ((addr % 64'(size)) != 64'd0) flt = 1'b1;
`endif
        a   = int'(addr[5:0]);
        val = 64'd0;
        if (flt) begin
            lat = 0;
        end else if (!we) begin
            lat = 1;
            for (int i = 0; i < size; i++) val[8*i +: 8] = ref_mem[a + i];
            if (!f3[2] && size < 8 && val[8*size-1])
                for (int i = size; i < 8; i++) val[8*i +: 8] = 8'hFF;
            exp_busy[k] = 1'b1;
            exp_rd[k]   = 1'b1;
            exp_addr[k] = addr;
        end else begin
            lat = (size == 8) ? 1 : 2;
            for (int i = 0; i < size; i++) ref_mem[a + i] = wdata[8*i +: 8];
            for (int c = k; c < k + lat; c++) exp_busy[c] = 1'b1;
            if (lat == 2) begin
                exp_rd[k]   = 1'b1;
                exp_addr[k] = addr;
            end
            exp_wr[k+lat-1]   = 1'b1;
            exp_addr[k+lat-1] = addr;
            for (int i = 0; i < 8; i++) exp_wd[k+lat-1][8*i +: 8] = ref_mem[a + i];
        end
        exp_rsp[k+lat]   = 1'b1;
        exp_fault[k+lat] = flt;
        exp_rdata[k+lat] = (flt || we) ? 64'd0 : val;
        if (lit_en) exp_lit[k+lat] = lit_val;

        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        for (int j = 0; j <= lat; j++) begin
            @(negedge clk);
            if (kill && j == 1) begin
                // unit is in the write cycle of the RMW: pull reset before the write edge
                #3 reset_n = 1'b0;
                exp_busy.delete(); exp_rd.delete(); exp_wr.delete(); exp_rsp.delete();
                exp_fault.delete(); exp_rdata.delete(); exp_addr.delete();
                exp_wd.delete(); exp_lit.delete();
                ref_mem = saved;
                bus.req_valid = 1'b0;
                @(negedge clk);
                @(negedge clk);
                #2 reset_n = 1'b1;
                @(negedge clk);
                return;
            end
            if (j < lat) drive_garbage();
            else bus.req_valid = 1'b0;
        end
    endtask

    initial begin
        logic [2:0]  f3;
        logic [63:0] addr;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 64'd0;
        bus.req_wdata  = 64'd0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);

        // ld of a doubleword holding one set byte
        poke(5, 8'h01);
        issue(1'b0, 3'b011, 64'd0, 64'd0, 1'b1, 64'h0000_0100_0000_0000, 1'b0);
        // sb via read-modify-write, then read it back inside a doubleword
        poke(20, 8'h03);
        issue(1'b1, 3'b000, 64'd20, 64'h0000_0000_0000_00AB, 1'b0, 64'd0, 1'b0);
        issue(1'b0, 3'b011, 64'd16, 64'd0, 1'b1, 64'h0000_00AB_0000_0000, 1'b0);
        // sign vs zero extension
        issue(1'b1, 3'b000, 64'd40, 64'h0000_0000_0000_0080, 1'b0, 64'd0, 1'b0);
        issue(1'b0, 3'b000, 64'd40, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        issue(1'b0, 3'b100, 64'd40, 64'd0, 1'b1, 64'h0000_0000_0000_0080, 1'b0);
        issue(1'b0, 3'b001, 64'd40, 64'd0, 1'b1, 64'h0000_0000_0000_0080, 1'b0);
        // range faults, including an address that would wrap in 64 bits
        issue(1'b0, 3'b011, 64'd60, 64'd0, 1'b1, 64'd0, 1'b0);
        issue(1'b1, 3'b011, 64'd57, 64'h1122_3344_5566_7788, 1'b0, 64'd0, 1'b0);
        issue(1'b0, 3'b000, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b1, 64'd0, 1'b0);
        // illegal codes
        issue(1'b0, 3'b111, 64'd0, 64'd0, 1'b1, 64'd0, 1'b0);
        issue(1'b1, 3'b100, 64'd0, 64'hFF, 1'b0, 64'd0, 1'b0);
        // unaligned word load
`ifdef LSU_ALIGN_CHECK_EN
        issue(1'b0, 3'b010, 64'd2, 64'd0, 1'b1, 64'd0, 1'b0);
`else
        issue(1'b0, 3'b010, 64'd2, 64'd0, 1'b1, 64'h0000_0000_0100_0000, 1'b0);
`endif
        // reset during the write cycle of an sh: memory must keep its old bytes
        poke(30, 8'h5A);
        poke(31, 8'hC3);
        issue(1'b1, 3'b001, 64'd30, 64'h0000_0000_0000_1234, 1'b0, 64'd0, 1'b1);
        issue(1'b0, 3'b101, 64'd30, 64'd0, 1'b1, 64'h0000_0000_0000_C35A, 1'b0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       addr = {$urandom, $urandom};
                1:       addr = 64'($urandom_range(50, 70));
                default: addr = 64'($urandom_range(0, 56));
            endcase
            issue(1'($urandom_range(0, 1)), f3, addr, {$urandom, $urandom}, 1'b0, 64'd0, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        do_final = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
